// File: rtl/ahb_arbiter_m3.sv
// Three-master AHB bus arbiter: one-hot HGRANT, HMASTER/HMASTLOCK address-phase owner,
// ownership held through fixed-length bursts and locked sequences.
module ahb_arbiter_m3 #(
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter bit          ROUND_ROBIN    = 1'b1
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HBUSREQ_0,
    input  logic       HBUSREQ_1,
    input  logic       HBUSREQ_2,
    input  logic       HLOCK_0,
    input  logic       HLOCK_1,
    input  logic       HLOCK_2,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HREADY,
    input  logic [1:0] HRESP,
    output logic       HGRANT_0,
    output logic       HGRANT_1,
    output logic       HGRANT_2,
    output logic [3:0] HMASTER,
    output logic       HMASTLOCK
);

    localparam int unsigned NM = 3;
    localparam int unsigned IW = 2;
    localparam int unsigned BW = 4;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [IW-1:0] DEF_IDX   = IW'(DEFAULT_MASTER);
    localparam logic [NM-1:0] GRANT_RST = NM'(1) << DEFAULT_MASTER;

    logic [NM-1:0] req;
    logic [NM-1:0] lock;
    logic [NM-1:0] grant_q, grant_d;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic [BW-1:0] beats_q, beats_d;
    logic [IW-1:0] master_q, master_d;
    logic          mastlock_q, mastlock_d;
    logic          hold_lock;
    logic          arb_ok;
    logic [2:0]    cand;

    assign req  = {HBUSREQ_2, HBUSREQ_1, HBUSREQ_0};
    assign lock = {HLOCK_2, HLOCK_1, HLOCK_0};

    // One-hot grant register to owner index
    always_comb begin
        grant_idx = '0;
        if (grant_q[1]) grant_idx = IW'(1);
        if (grant_q[2]) grant_idx = IW'(2);
    end

    // Remaining-beat counter; a non-OKAY response aborts the burst regardless of HREADY
    always_comb begin
        beats_d = beats_q;
        if (HRESP != RESP_OKAY) begin
            beats_d = '0;
        end else if (HREADY) begin
            case (HTRANS)
                TR_NONSEQ: begin
                    case (HBURST)
                        3'b010, 3'b011: beats_d = BW'(3);
                        3'b100, 3'b101: beats_d = BW'(7);
                        3'b110, 3'b111: beats_d = BW'(15);
                        default:        beats_d = '0;
                    endcase
                end
                TR_SEQ: begin
                    if (beats_q != '0) beats_d = beats_q - BW'(1);
                end
                TR_IDLE: beats_d = '0;
                default: beats_d = beats_q;
            endcase
        end
    end

    assign hold_lock = lock[grant_idx];
    assign arb_ok    = (beats_d <= BW'(1)) && !hold_lock;

    // Winner selection; rotating search leaves the current owner for last
    always_comb begin
        win_idx   = DEF_IDX;
        win_found = 1'b0;
        cand      = '0;
        if (ROUND_ROBIN) begin
            for (int k = 1; k <= 3; k++) begin
                cand = 3'(grant_idx) + 3'(k);
                if (cand >= 3'd3) cand = cand - 3'd3;
                if (!win_found && req[IW'(cand)]) begin
                    win_idx   = IW'(cand);
                    win_found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!win_found && req[k]) begin
                    win_idx   = IW'(k);
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_d    = arb_ok ? (NM'(1) << win_idx) : grant_q;
        master_d   = HREADY ? grant_idx : master_q;
        mastlock_d = HREADY ? lock[grant_idx] : mastlock_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q    <= GRANT_RST;
            beats_q    <= '0;
            master_q   <= DEF_IDX;
            mastlock_q <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            beats_q    <= beats_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
        end
    end

    assign HGRANT_0  = grant_q[0];
    assign HGRANT_1  = grant_q[1];
    assign HGRANT_2  = grant_q[2];
    assign HMASTER   = {2'b00, master_q};
    assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_m3.sv
// Directed bench for ahb_arbiter_m3: round-robin instance (default master 0) plus a
// fixed-priority instance (default master 2) sharing the same bus inputs.
module tb_ahb_arbiter_m3;

    logic       clk;
    logic       rst;
    logic       req0, req1, req2;
    logic       lck0, lck1, lck2;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;

    logic       g0, g1, g2;
    logic [3:0] hmaster;
    logic       hmastlock;
    logic       f_g0, f_g1, f_g2;
    logic [3:0] f_hmaster;
    logic       f_hmastlock;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_arbiter_m3 #(.DEFAULT_MASTER(0), .ROUND_ROBIN(1'b1)) u_rr (
        .HCLK(clk), .HRESET(rst),
        .HBUSREQ_0(req0), .HBUSREQ_1(req1), .HBUSREQ_2(req2),
        .HLOCK_0(lck0), .HLOCK_1(lck1), .HLOCK_2(lck2),
        .HTRANS(htrans), .HBURST(hburst), .HREADY(hready), .HRESP(hresp),
        .HGRANT_0(g0), .HGRANT_1(g1), .HGRANT_2(g2),
        .HMASTER(hmaster), .HMASTLOCK(hmastlock)
    );

    ahb_arbiter_m3 #(.DEFAULT_MASTER(2), .ROUND_ROBIN(1'b0)) u_fix (
        .HCLK(clk), .HRESET(rst),
        .HBUSREQ_0(req0), .HBUSREQ_1(req1), .HBUSREQ_2(req2),
        .HLOCK_0(lck0), .HLOCK_1(lck1), .HLOCK_2(lck2),
        .HTRANS(htrans), .HBURST(hburst), .HREADY(hready), .HRESP(hresp),
        .HGRANT_0(f_g0), .HGRANT_1(f_g1), .HGRANT_2(f_g2),
        .HMASTER(f_hmaster), .HMASTLOCK(f_hmastlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        lck0 = 1'b0; lck1 = 1'b0; lck2 = 1'b0;
        htrans = 2'b00; hburst = 3'b000; hready = 1'b1; hresp = 2'b00;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({g2, g1, g0} !== 3'b001) begin
                n_fail++;
                $display("FAIL reset_grant cyc %0d: got %b expected 001", i, {g2, g1, g0});
            end
            n_checks++;
            if (hmaster !== 4'd0 || hmastlock !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_master cyc %0d: got hmaster=%0d lock=%b expected 0/0", i, hmaster, hmastlock);
            end
            n_checks++;
            if ({f_g2, f_g1, f_g0} !== 3'b100 || f_hmaster !== 4'd2) begin
                n_fail++;
                $display("FAIL reset_fixed cyc %0d: got grant=%b hmaster=%0d expected 100/2", i, {f_g2, f_g1, f_g0}, f_hmaster);
            end
            tick();
        end
    endtask

    task automatic test_request();
        do_reset();
        req1 = 1'b1;
        tick();
        n_checks++;
        if ({g2, g1, g0} !== 3'b010 || hmaster !== 4'd0) begin
            n_fail++;
            $display("FAIL request_grant: got grant=%b hmaster=%0d expected 010/0", {g2, g1, g0}, hmaster);
        end
        tick();
        n_checks++;
        if ({g2, g1, g0} !== 3'b010 || hmaster !== 4'd1) begin
            n_fail++;
            $display("FAIL request_master: got grant=%b hmaster=%0d expected 010/1", {g2, g1, g0}, hmaster);
        end
        n_checks++;
        if ({f_g2, f_g1, f_g0} !== 3'b010 || f_hmaster !== 4'd1) begin
            n_fail++;
            $display("FAIL request_fixed: got grant=%b hmaster=%0d expected 010/1", {f_g2, f_g1, f_g0}, f_hmaster);
        end
    endtask

    task automatic test_rotate();
        int exp_g[4];
        int exp_m[4];
        logic [2:0] exp_oh;
        exp_g = '{1, 2, 0, 1};
        exp_m = '{0, 1, 2, 0};
        do_reset();
        req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        htrans = 2'b10; hburst = 3'b000;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_oh = 3'(1) << exp_g[i];
            n_checks++;
            if ({g2, g1, g0} !== exp_oh) begin
                n_fail++;
                $display("FAIL rotate_grant step %0d: got %b expected %b", i, {g2, g1, g0}, exp_oh);
            end
            n_checks++;
            if (hmaster !== 4'(exp_m[i])) begin
                n_fail++;
                $display("FAIL rotate_master step %0d: got %0d expected %0d", i, hmaster, exp_m[i]);
            end
            n_checks++;
            if ({f_g2, f_g1, f_g0} !== 3'b001) begin
                n_fail++;
                $display("FAIL fixed_priority step %0d: got %b expected 001", i, {f_g2, f_g1, f_g0});
            end
        end
    endtask

    task automatic test_burst();
        do_reset();
        req1 = 1'b1;
        tick();
        tick();
        htrans = 2'b10; hburst = 3'b011; req2 = 1'b1;
        tick();
        n_checks++;
        if ({g2, g1, g0} !== 3'b010 || hmaster !== 4'd1) begin
            n_fail++;
            $display("FAIL burst_nonseq: got grant=%b hmaster=%0d expected 010/1", {g2, g1, g0}, hmaster);
        end
        htrans = 2'b11;
        tick();
        n_checks++;
        if ({g2, g1, g0} !== 3'b010) begin
            n_fail++;
            $display("FAIL burst_seq1: got grant=%b expected 010", {g2, g1, g0});
        end
        tick();
        n_checks++;
        if ({g2, g1, g0} !== 3'b100 || hmaster !== 4'd1) begin
            n_fail++;
            $display("FAIL burst_seq2: got grant=%b hmaster=%0d expected 100/1", {g2, g1, g0}, hmaster);
        end
        req1 = 1'b0;
        tick();
        n_checks++;
        if ({g2, g1, g0} !== 3'b100 || hmaster !== 4'd2) begin
            n_fail++;
            $display("FAIL burst_last: got grant=%b hmaster=%0d expected 100/2", {g2, g1, g0}, hmaster);
        end
        htrans = 2'b00;
    endtask

    task automatic test_lock();
        do_reset();
        req0 = 1'b1; lck0 = 1'b1; req1 = 1'b1;
        htrans = 2'b10; hburst = 3'b001;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if ({g2, g1, g0} !== 3'b001 || hmastlock !== 1'b1) begin
                n_fail++;
                $display("FAIL lock_hold cyc %0d: got grant=%b lock=%b expected 001/1", i, {g2, g1, g0}, hmastlock);
            end
        end
        lck0 = 1'b0; req0 = 1'b0;
        tick();
        n_checks++;
        if ({g2, g1, g0} !== 3'b010 || hmastlock !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_release: got grant=%b lock=%b expected 010/0", {g2, g1, g0}, hmastlock);
        end
    endtask

    task automatic test_error();
        do_reset();
        req2 = 1'b1;
        tick();
        tick();
        htrans = 2'b10; hburst = 3'b101; req0 = 1'b1;
        tick();
        htrans = 2'b11;
        tick();
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({g2, g1, g0} !== 3'b100 || hmaster !== 4'd2) begin
                n_fail++;
                $display("FAIL wait_stable cyc %0d: got grant=%b hmaster=%0d expected 100/2", i, {g2, g1, g0}, hmaster);
            end
        end
        hresp = 2'b01;
        tick();
        n_checks++;
        if ({g2, g1, g0} !== 3'b001 || hmaster !== 4'd2) begin
            n_fail++;
            $display("FAIL error_regrant: got grant=%b hmaster=%0d expected 001/2", {g2, g1, g0}, hmaster);
        end
        hready = 1'b1; htrans = 2'b00;
        tick();
        n_checks++;
        if (hmaster !== 4'd0) begin
            n_fail++;
            $display("FAIL error_master: got %0d expected 0", hmaster);
        end
        hresp = 2'b00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req2 = 1'b1;
        tick();
        tick();
        htrans = 2'b10; hburst = 3'b101; req0 = 1'b1;
        tick();
        htrans = 2'b11; lck2 = 1'b1;
        tick();
        n_checks++;
        if (hmastlock !== 1'b1 || hmaster !== 4'd2) begin
            n_fail++;
            $display("FAIL pre_reset: got lock=%b hmaster=%0d expected 1/2", hmastlock, hmaster);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({g2, g1, g0} !== 3'b001 || hmaster !== 4'd0 || hmastlock !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got grant=%b hmaster=%0d lock=%b expected 001/0/0", {g2, g1, g0}, hmaster, hmastlock);
        end
        rst = 1'b0; lck2 = 1'b0; req0 = 1'b0; req2 = 1'b0; req1 = 1'b1;
        tick();
        n_checks++;
        if ({g2, g1, g0} !== 3'b010) begin
            n_fail++;
            $display("FAIL counter_cleared: got grant=%b expected 010", {g2, g1, g0});
        end
    endtask

    task automatic test_default();
        do_reset();
        req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        htrans = 2'b10;
        tick();
        tick();
        req0 = 1'b0;
        tick();
        n_checks++;
        if ({f_g2, f_g1, f_g0} !== 3'b010 || f_hmaster !== 4'd0) begin
            n_fail++;
            $display("FAIL fixed_next: got grant=%b hmaster=%0d expected 010/0", {f_g2, f_g1, f_g0}, f_hmaster);
        end
        req1 = 1'b0; req2 = 1'b0;
        tick();
        n_checks++;
        if ({f_g2, f_g1, f_g0} !== 3'b100 || {g2, g1, g0} !== 3'b001) begin
            n_fail++;
            $display("FAIL park_default: got fixed=%b rr=%b expected 100/001", {f_g2, f_g1, f_g0}, {g2, g1, g0});
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_request();
        test_rotate();
        test_burst();
        test_lock();
        test_error();
        test_reset_mid();
        test_default();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
